mb16_issue_ctrl: RTL and testbench

//  Initiator-side controller for the registered 16x16 radix-4 Booth multiplier (mb16_td).

---
 rtl/mb16_pkg.sv | 17 +
 rtl/mb16_result_fifo.sv | 54 +++++
 rtl/mb16_issue_ctrl.sv | 108 ++++++++++
 tb/tb_mb16_issue_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mb16_pkg.sv
// Shared constants and result payload for the mb16 multiplier issue controller.
package mb16_pkg;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned TAGW       = 4;
  localparam int unsigned PROD_W     = 2 * WIDTH;
  localparam int unsigned MUL_LAT    = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;

  typedef struct packed {
    logic [PROD_W-1:0] product;
    logic [TAGW-1:0]   tag;
  } result_t;

endpackage

// File: rtl/mb16_result_fifo.sv
// Result FIFO with a registered head entry so the downstream outputs come straight from flops.
module mb16_result_fifo
  import mb16_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  result_t          wdata,
  input  logic             pop,
  output result_t          head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  result_t          mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] cnt_next;
  result_t          head_next;

  // Next head: a word written this edge into an otherwise empty FIFO bypasses the array.
  always_comb begin
    rd_next   = rd_ptr + PTR_W'(pop);
    cnt_next  = count + CNT_W'(push) - CNT_W'(pop);
    head_next = '0;
    if (cnt_next != '0) begin
      if (push && (rd_next == wr_ptr)) head_next = wdata;
      else                             head_next = mem[rd_next];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) mem[wr_ptr] <= wdata;
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_next;
      count  <= cnt_next;
      head   <= head_next;
      full   <= (cnt_next == CNT_W'(FIFO_DEPTH));
      empty  <= (cnt_next == '0);
    end
  end

endmodule

// File: rtl/mb16_issue_ctrl.sv
// Issue controller for the registered radix-4 Booth multiplier: credit-gated issue, latency
// tracking, in-order result FIFO. Optional perf counters when MB16_ISSUE_PERF_EN is defined.
module mb16_issue_ctrl
  import mb16_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [TAGW-1:0]   in_tag,
  output logic [WIDTH-1:0]  mul_mx,
  output logic [WIDTH-1:0]  mul_my,
  input  logic [PROD_W-1:0] mul_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic [TAGW-1:0]   out_tag,
`ifdef MB16_ISSUE_PERF_EN
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall,
`endif
  output logic              busy
);

  logic             issue_c;
  logic             pop_c;
  logic [MUL_LAT-1:0] sr_vld;
  logic [TAGW-1:0]  sr_tag [MUL_LAT];
  logic [CNT_W-1:0] inflight_c;
  logic [CNT_W-1:0] credit_next_c;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  result_t          fifo_head;
  result_t          capture_c;

  assign issue_c   = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;
  assign mul_mx    = issue_c ? in_a : '0;
  assign mul_my    = issue_c ? in_b : '0;
  assign capture_c = '{product: mul_product, tag: sr_tag[MUL_LAT-1]};

  // Tag/valid pipeline aligned with the multiplier's operand and product registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sr_vld <= '0;
      for (int i = 0; i < int'(MUL_LAT); i++) sr_tag[i] <= '0;
    end else begin
      sr_vld[0] <= issue_c;
      sr_tag[0] <= in_tag;
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        sr_vld[i] <= sr_vld[i-1];
        sr_tag[i] <= sr_tag[i-1];
      end
    end
  end

  // Credits count every pair not yet popped, whether still in the multiplier or buffered.
  always_comb begin
    inflight_c = '0;
    for (int i = 0; i < int'(MUL_LAT); i++) inflight_c = inflight_c + CNT_W'(sr_vld[i]);
    credit_next_c = inflight_c + fifo_count + CNT_W'(issue_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      in_ready <= (credit_next_c < CNT_W'(FIFO_DEPTH));
      busy     <= (credit_next_c != '0);
    end
  end

  mb16_result_fifo u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (sr_vld[MUL_LAT-1]),
    .wdata (capture_c),
    .pop   (pop_c),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid   = !fifo_empty;
  assign out_product = fifo_head.product;
  assign out_tag     = fifo_head.tag;

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RST)
    !(fifo_full && sr_vld[MUL_LAT-1] && !pop_c));

`ifdef MB16_ISSUE_PERF_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (issue_c)               perf_issued <= perf_issued + 32'd1;
      if (in_valid && !in_ready) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mb16_issue_ctrl.sv
// Bench for mb16_issue_ctrl: behavioural multiplier, queue-based reference model, directed scenarios.
module tb_mb16_issue_ctrl;
  import mb16_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] mul_mx, mul_my;
  logic [31:0] mul_product, out_product;
  logic [3:0]  out_tag;
`ifdef MB16_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  mb16_issue_ctrl dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .mul_mx(mul_mx), .mul_my(mul_my),
    .mul_product(mul_product), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_tag(out_tag),
`ifdef MB16_ISSUE_PERF_EN
    .perf_issued(perf_issued), .perf_stall(perf_stall),
`endif
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Two-stage registered multiplier: operand register then product register.
  logic signed [15:0] mx_q = '0, my_q = '0;
  logic signed [31:0] prod_q = '0;
  always @(posedge CLK) begin
    mx_q   <= mul_mx;
    my_q   <= mul_my;
    prod_q <= mx_q * my_q;
  end
  assign mul_product = prod_q;

  typedef struct {
    logic [31:0] prod;
    logic [3:0]  tag;
    int          rdy;
  } item_t;

  item_t       q[$];
  item_t       it;
  logic [31:0] pop_prod[$];
  logic [3:0]  pop_tag[$];
  int          pop_cyc[$];
  int          iss_cyc[$];
  int          cyc = 0, total = 0, bad = 0, stalls = 0;
  bit          seen = 0, exp_rdy, exp_vld, iss;
  int          pa, pb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: every pair not yet popped is in q; head visible 3 cycles after issue.
  always @(negedge CLK) begin
    cyc++;
    if (!RST) begin
      q.delete();
      seen   = 0;
      stalls = 0;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_product", out_product, 0);
      check("rst_tag", out_tag, 0);
      check("rst_mx", mul_mx, 0);
      check("rst_my", mul_my, 0);
    end else begin
      exp_rdy = seen && (q.size() < 4);
      exp_vld = (q.size() > 0) && (q[0].rdy <= cyc);
      iss     = in_valid && exp_rdy;
      check("in_ready", in_ready, exp_rdy);
      check("busy", busy, q.size() != 0);
      check("out_valid", out_valid, exp_vld);
      if (exp_vld) begin
        check("out_product", out_product, q[0].prod);
        check("out_tag", out_tag, q[0].tag);
      end
      check("mul_mx", mul_mx, iss ? in_a : 16'h0);
      check("mul_my", mul_my, iss ? in_b : 16'h0);
      if (exp_vld && out_ready) begin
        pop_prod.push_back(out_product);
        pop_tag.push_back(out_tag);
        pop_cyc.push_back(cyc);
        void'(q.pop_front());
      end
      if (iss) begin
        pa = int'($signed(in_a));
        pb = int'($signed(in_b));
        it.prod = 32'(pa * pb);
        it.tag  = in_tag;
        it.rdy  = cyc + 3;
        q.push_back(it);
        iss_cyc.push_back(cyc);
      end
      if (in_valid && !exp_rdy) stalls++;
      seen = 1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int retries = 0;
  // Present a pair and hold it until accepted; leaves it driven so pairs can go back-to-back.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
    bit ok = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      if (in_ready) ok = 1; else retries++;
      tick();
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: got no accept want accept for tag %0d", tag);
    end
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge CLK);
      if (!busy && !out_valid) done = 1;
      tick();
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout: got busy want idle");
    end
  endtask

  int base, acc, n;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    RST = 1'b1;
    tick();

    // Single issue, signed result, latency 3
    out_ready = 1'b1;
    base = pop_prod.size();
    send(16'd3, 16'hFFFB, 4'd2);
    idle_in();
    for (int i = 0; i < 10 && pop_prod.size() == base; i++) tick();
    check("s1_count", pop_prod.size(), base + 1);
    if (pop_prod.size() == base + 1) begin
      check("s1_product", pop_prod[base], 32'hFFFFFFF1);
      check("s1_tag", pop_tag[base], 4'd2);
      check("s1_latency", pop_cyc[base] - iss_cyc[iss_cyc.size()-1], 3);
    end
    drain();

    // Stream of 8 back-to-back pairs
    base = pop_prod.size();
    retries = 0;
    for (int k = 0; k < 8; k++) send(16'(k * 300 - 1000), 16'(7 - k * 11), 4'(k + 3));
    idle_in();
    drain();
    check("s2_count", pop_prod.size(), base + 8);
    check("s2_no_stall", retries, 0);
    if (pop_prod.size() == base + 8) begin
      check("s2_rate", pop_cyc[base+7] - pop_cyc[base], 7);
      check("s2_last_tag", pop_tag[base+7], 4'd10);
      check("s2_first_prod", pop_prod[base], 32'hFFFF_E4A8);
    end

    // Extremes
    base = pop_prod.size();
    send(16'h8000, 16'h8000, 4'd7);
    send(16'h7FFF, 16'h8000, 4'd8);
    send(16'h0000, 16'h1234, 4'd9);
    idle_in();
    drain();
    check("s4_count", pop_prod.size(), base + 3);
    if (pop_prod.size() == base + 3) begin
      check("s4_min_min", pop_prod[base], 32'h40000000);
      check("s4_max_min", pop_prod[base+1], 32'hC0008000);
      check("s4_zero", pop_prod[base+2], 32'h0);
    end

    // Back-pressure: only FIFO_DEPTH accepted while out_ready=0
    RST = 1'b0; tick(); tick(); RST = 1'b1; tick();
    out_ready = 1'b0;
    base = pop_prod.size();
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_a = 16'(acc * 5 + 1); in_b = 16'(-(acc + 2)); in_tag = 4'(acc + 1);
      @(negedge CLK);
      if (in_ready) acc++;
      tick();
    end
    check("s3_accepted", acc, 4);
    check("s3_held_off", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && acc < 6; i++) begin
      in_valid = 1'b1; in_a = 16'(acc * 5 + 1); in_b = 16'(-(acc + 2)); in_tag = 4'(acc + 1);
      @(negedge CLK);
      if (in_ready) acc++;
      tick();
    end
    idle_in();
    drain();
    check("s3_total", acc, 6);
    check("s3_count", pop_prod.size(), base + 6);
    if (pop_prod.size() == base + 6) begin
      for (int k = 0; k < 6; k++) check("s3_order", pop_tag[base+k], 4'(k + 1));
      check("s3_first_prod", pop_prod[base], 32'hFFFFFFFE);
    end
`ifdef MB16_ISSUE_PERF_EN
    check("perf_issued", perf_issued, 32'd6);
    check("perf_stall", perf_stall, 32'(stalls));
`endif

    // Reset with two pairs in flight and two buffered
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(16'(k + 1), 16'd9, 4'(k + 11));
    idle_in();
    check("s5_pre_valid", out_valid, 1);
    base = pop_prod.size();
    RST = 1'b0;
    #1;
    check("s5_async_valid", out_valid, 0);
    check("s5_async_product", out_product, 0);
    check("s5_async_busy", busy, 0);
    tick(); tick();
    RST = 1'b1;
    out_ready = 1'b1;
    repeat (8) tick();
    check("s5_no_stale", pop_prod.size(), base);
    check("s5_idle_valid", out_valid, 0);

    // Traffic still flows after the mid-operation reset
    n = pop_prod.size();
    send(16'hFFFF, 16'hFFFF, 4'd5);
    idle_in();
    drain();
    check("s5_after_count", pop_prod.size(), n + 1);
    if (pop_prod.size() == n + 1) check("s5_after_prod", pop_prod[n], 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
